lw_sha_dma_feeder: RTL and testbench

LW_SHA_DMA_FEEDER -- requirements
Module: lw_sha_dma_feeder

---
 rtl/lw_sha_dma_feeder.sv | 172 +++++++++++++++++
 tb/tb_lw_sha_dma_feeder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lw_sha_dma_feeder.sv
// lw_sha_dma_feeder
// Buffers a message word stream in a small FIFO and forwards it to the SHA
// core's DIN register as AXI4 write bursts. Words stay in the FIFO until their
// burst receives a write response. Only then are they committed (freed).
//
// Optional build macro:
//   LW_SHA_FEEDER_RETRY_EN - when defined, an error response rewinds the read
//                            pointer so that the same words are sent again.
//                            When undefined, an error response drops the words.
//
// Ports:
//   aclk, aresetn           clock, synchronous active-low reset
//   s_data/s_valid/s_ready  message word stream in
//   dma_wr_req_i            downstream core can accept DIN words
//   aw*                     AXI4 write address channel (master)
//   w*                      AXI4 write data channel (master)
//   bresp/bvalid/bready     AXI4 write response channel
//   err_o                   one-cycle pulse on a non-OKAY write response
//   level_o                 committed FIFO occupancy

`ifndef FIQSHA_BUS
`define FIQSHA_BUS 32
`endif

module lw_sha_dma_feeder #(
  parameter int unsigned DATA_WIDTH = `FIQSHA_BUS,
  parameter logic [11:0] DIN_ADDR   = 12'h000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          dma_wr_req_i,
  output logic [11:0]                   awaddr,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic [3:0]                    awid,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready,
  output logic                          err_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DepthW    = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] MaxBurstW = LW'(MAX_BURST);
  localparam logic [2:0]    AxSize    = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e                state_q;
  // Pointers carry one extra wrap bit so that full and empty differ.
  logic [AW:0]           wr_ptr_q, commit_ptr_q, spec_ptr_q;
  logic [LW-1:0]         len_q, beat_q;
  logic                  awvalid_q, wvalid_q, wlast_q, bready_q, err_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic          push;
  logic [LW-1:0] level;
  logic [LW-1:0] burst_len;

  assign level     = wr_ptr_q - commit_ptr_q;
  assign s_ready   = (level != DepthW);
  assign push      = s_valid && s_ready;
  assign burst_len = (level > MaxBurstW) ? MaxBurstW : level;

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      spec_ptr_q   <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (dma_wr_req_i && (level != '0)) begin
            len_q     <= burst_len;
            beat_q    <= '0;
            awvalid_q <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (len_q == LW'(1));
            state_q   <= StData;
          end
        end
        StData: begin
          if (wready) begin
            spec_ptr_q <= spec_ptr_q + 1'b1;
            beat_q     <= beat_q + 1'b1;
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= StResp;
            end else begin
              // Next beat index is beat_q + 1; it is last when it equals len - 1.
              wlast_q <= ((beat_q + LW'(2)) == len_q);
            end
          end
        end
        StResp: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            state_q  <= StIdle;
            if (bresp == 2'b00) begin
              commit_ptr_q <= spec_ptr_q;
            end else begin
              err_q <= 1'b1;
`ifdef LW_SHA_FEEDER_RETRY_EN
              spec_ptr_q <= commit_ptr_q;
`else
              commit_ptr_q <= spec_ptr_q;
`endif
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Address fields read as zero outside the address phase.
  assign awvalid = awvalid_q;
  assign awaddr  = awvalid_q ? DIN_ADDR : '0;
  assign awlen   = awvalid_q ? 8'(len_q - 1'b1) : '0;
  assign awsize  = awvalid_q ? AxSize : '0;
  assign awburst = 2'b00;
  assign awid    = 4'h0;
  // spec_ptr_q only moves on a handshake, so wdata is stable while stalled.
  assign wdata   = wvalid_q ? mem_q[spec_ptr_q[AW-1:0]] : '0;
  assign wlast   = wlast_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign err_o   = err_q;
  assign level_o = level;

endmodule

// File: tb/tb_lw_sha_dma_feeder.sv
// Self-checking bench for lw_sha_dma_feeder: a queue-based model of the FIFO
// and the one-burst-at-a-time bus protocol is checked every cycle, with
// directed scenarios pinned by literal expectations, then random traffic.

module tb_lw_sha_dma_feeder;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int MB = 4;
  localparam int PIdle = 0, PAddr = 1, PData = 2, PResp = 3;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready, dma_wr_req_i;
  logic [11:0]   awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic [3:0]    awid;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready, err_o;
  logic [3:0]    level_o;

  always #5 aclk = ~aclk;

  lw_sha_dma_feeder #(
    .DATA_WIDTH (DW),
    .DIN_ADDR   (12'h000),
    .FIFO_DEPTH (DEPTH),
    .MAX_BURST  (MB)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .dma_wr_req_i (dma_wr_req_i),
    .awaddr       (awaddr),
    .awlen        (awlen),
    .awsize       (awsize),
    .awburst      (awburst),
    .awid         (awid),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wlast        (wlast),
    .wvalid       (wvalid),
    .wready       (wready),
    .bresp        (bresp),
    .bvalid       (bvalid),
    .bready       (bready),
    .err_o        (err_o),
    .level_o      (level_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no event within the cycle budget, expected one", what);
  endtask

  // Behavioural model: queue of uncommitted words, count of words sent but
  // not yet acknowledged, and which bus phase the single burst is in.
  logic [DW-1:0] mq[$];
  int            m_spec = 0, m_len = 0, m_beat = 0, m_phase = PIdle;
  logic          m_err = 1'b0;
  bit            mon_en = 0;
  bit            m_push;
  logic [DW-1:0] m_pd;
  logic [7:0]    aw_log[$];
  logic [DW:0]   w_log[$];
  int            b_count = 0;
  int            err_count = 0;

  // Compare the current cycle, then advance the model across the next edge
  // using the inputs already driven for it.
  always @(negedge aclk) begin
    if (mon_en) begin
      check("level_o", level_o, mq.size());
      check("s_ready", s_ready, mq.size() != DEPTH);
      check("awvalid", awvalid, m_phase == PAddr);
      check("wvalid", wvalid, m_phase == PData);
      check("bready", bready, m_phase == PResp);
      check("err_o", err_o, m_err);
      if (err_o) err_count++;
      if (m_phase == PAddr) begin
        check("awlen", awlen, m_len - 1);
        check("aw_fields", {awaddr, awsize, awburst, awid}, {12'h000, 3'd2, 2'b00, 4'h0});
      end
      if (m_phase == PData) begin
        check("wdata", wdata, mq[m_spec]);
        check("wlast", wlast, m_beat == m_len - 1);
      end

      if (!aresetn) begin
        mq.delete();
        m_spec  = 0;
        m_phase = PIdle;
        m_err   = 1'b0;
      end else begin
        m_push = s_valid && (mq.size() != DEPTH);
        m_pd   = s_data;
        m_err  = 1'b0;
        case (m_phase)
          PIdle: begin
            if (dma_wr_req_i && mq.size() != 0) begin
              m_len   = (mq.size() < MB) ? mq.size() : MB;
              m_beat  = 0;
              m_phase = PAddr;
            end
          end
          PAddr: begin
            if (awready) begin
              aw_log.push_back(awlen);
              m_phase = PData;
            end
          end
          PData: begin
            if (wready) begin
              w_log.push_back({wlast, wdata});
              m_spec++;
              m_beat++;
              if (m_beat == m_len) m_phase = PResp;
            end
          end
          default: begin
            if (bvalid) begin
              b_count++;
              m_phase = PIdle;
              if (bresp != 2'b00) m_err = 1'b1;
`ifdef LW_SHA_FEEDER_RETRY_EN
              if (bresp != 2'b00) m_spec = 0;
`endif
              for (int i = 0; i < m_spec; i++) void'(mq.pop_front());
              m_spec = 0;
            end
          end
        endcase
        if (m_push) mq.push_back(m_pd);
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    int budget = 300;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && budget > 0) begin
      step();
      budget--;
    end
    if (!s_ready) fail_timeout("push");
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_bursts(input int target);
    int budget = 500;
    while (b_count < target && budget > 0) begin
      step();
      budget--;
    end
    if (b_count < target) fail_timeout("burst_done");
    step();
  endtask

  task automatic wait_beat(input int n);
    int budget = 200;
    while (!(wvalid && w_log.size() == n) && budget > 0) begin
      step();
      budget--;
    end
    if (!(wvalid && w_log.size() == n)) fail_timeout("data_beat");
  endtask

  task automatic drain();
    int budget = 500;
    dma_wr_req_i = 1'b1;
    while (level_o != 0 && budget > 0) begin
      step();
      budget--;
    end
    if (level_o != 0) fail_timeout("drain");
    dma_wr_req_i = 1'b0;
    step();
  endtask

  task automatic clear_logs();
    aw_log.delete();
    w_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int errs;
    aresetn = 1'b0;
    s_valid = 1'b0; s_data = '0; dma_wr_req_i = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (3) step();
    check("rst_level", level_o, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_valids", {awvalid, wvalid, wlast, bready, err_o}, 5'b0);
    check("rst_aw_fields", {awaddr, awlen, awsize, awburst, awid}, 29'h0);
    check("rst_wdata", wdata, 0);
    aresetn = 1'b1;
    mon_en  = 1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    step();

    // Three words make one burst of three beats.
    clear_logs();
    base = b_count;
    push(32'hA);
    push(32'hB);
    push(32'hC);
    check("t1_level3", level_o, 3);
    dma_wr_req_i = 1'b1;
    wait_bursts(base + 1);
    dma_wr_req_i = 1'b0;
    check("t1_nbursts", aw_log.size(), 1);
    check("t1_awlen", aw_log[0], 8'h02);
    check("t1_beat0", w_log[0], {1'b0, 32'hA});
    check("t1_beat1", w_log[1], {1'b0, 32'hB});
    check("t1_beat2", w_log[2], {1'b1, 32'hC});
    check("t1_level0", level_o, 0);

    // Ten words into an eight-deep FIFO.
    clear_logs();
    base = b_count;
    for (int i = 0; i < 8; i++) push(32'h100 + i);
    check("t2_full_ready", s_ready, 0);
    check("t2_full_level", level_o, 8);
    dma_wr_req_i = 1'b1;
    push(32'h108);
    push(32'h109);
    wait_bursts(base + 3);
    dma_wr_req_i = 1'b0;
    check("t2_nbursts", aw_log.size(), 3);
    check("t2_awlen0", aw_log[0], 3);
    check("t2_awlen1", aw_log[1], 3);
    check("t2_awlen2", aw_log[2], 1);
    for (int i = 0; i < 10; i++) check("t2_order", w_log[i][DW-1:0], 32'h100 + i);

    // Stall beat 2 for five cycles.
    clear_logs();
    base = b_count;
    for (int i = 0; i < 4; i++) push(32'h200 + i);
    dma_wr_req_i = 1'b1;
    wait_beat(2);
    wready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_stall_wdata", wdata, 32'h202);
      check("t3_stall_wlast", wlast, 0);
    end
    wready = 1'b1;
    wait_bursts(base + 1);
    dma_wr_req_i = 1'b0;
    for (int i = 0; i < 4; i++) check("t3_order", w_log[i][DW-1:0], 32'h200 + i);

    // Error response on words 1..4.
    clear_logs();
    base = b_count;
    errs = err_count;
    for (int i = 1; i <= 4; i++) push(i);
    bresp = 2'b10;
    dma_wr_req_i = 1'b1;
    begin
      int budget = 200;
      while (b_count < base + 1 && budget > 0) begin
        step();
        budget--;
      end
      if (b_count < base + 1) fail_timeout("err_burst");
    end
    dma_wr_req_i = 1'b0;
    bresp = 2'b00;
    step();
    step();
    check("t4_err_pulses", err_count - errs, 1);
`ifdef LW_SHA_FEEDER_RETRY_EN
    check("t4_level", level_o, 4);
`else
    check("t4_level", level_o, 0);
`endif
    push(5);
    dma_wr_req_i = 1'b1;
    wait_bursts(base + 2);
    dma_wr_req_i = 1'b0;
`ifdef LW_SHA_FEEDER_RETRY_EN
    check("t4_resend_first", w_log[4][DW-1:0], 1);
    check("t4_resend_awlen", aw_log[1], 3);
`else
    check("t4_next_word", w_log[4][DW-1:0], 5);
    check("t4_next_awlen", aw_log[1], 0);
`endif
    drain();

    // Commit of four words from a full FIFO while a new word is offered.
    clear_logs();
    for (int i = 0; i < 8; i++) push(32'h400 + i);
    check("t5_level8", level_o, 8);
    dma_wr_req_i = 1'b1;
    begin
      int budget = 200;
      while (!bready && budget > 0) begin
        step();
        budget--;
      end
      if (!bready) fail_timeout("t5_bready");
    end
    dma_wr_req_i = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h408;
    step();
    step();
    s_valid = 1'b0;
    check("t5_level5", level_o, 5);
    drain();

    // Reset during data beat 1.
    clear_logs();
    for (int i = 0; i < 4; i++) push(32'h500 + i);
    dma_wr_req_i = 1'b1;
    wait_beat(1);
    aresetn = 1'b0;
    step();
    check("t6_wvalid", wvalid, 0);
    check("t6_level", level_o, 0);
    check("t6_bready", bready, 0);
    check("t6_awvalid", awvalid, 0);
    aresetn = 1'b1;
    dma_wr_req_i = 1'b0;
    step();

    // Random traffic, with occasional resets and error responses.
    for (int c = 0; c < 3000; c++) begin
      s_valid      = 1'($urandom_range(0, 1));
      s_data       = $urandom;
      dma_wr_req_i = ($urandom_range(0, 9) < 7);
      awready      = ($urandom_range(0, 2) != 0);
      wready       = ($urandom_range(0, 2) != 0);
      bvalid       = 1'($urandom_range(0, 1));
      bresp        = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      aresetn      = ($urandom_range(0, 399) != 0);
      step();
    end
    aresetn = 1'b1;
    s_valid = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
